sram_rw_arbiter: RTL
====================

SRAM_RW_ARBITER -- requirements
Module: sram_rw_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 9, SRAM address width.
REQ-002 The block SHALL have parameter DATA_W, default 16, SRAM data width.
REQ-003 The block SHALL have parameter DEPTH, default 512, number of SRAM entries swept by init (DEPTH = 2^ADDR_W).
REQ-004 Port: clock  in  1  sole clock, all state on rising edge.
REQ-005 Port: reset  in  1  reset, asynchronous, active-high.
REQ-006 Ports per requester n in {0,1}: reqN_valid in 1; reqN_ready out 1; reqN_write in 1; reqN_addr in ADDR_W; reqN_wdata in DATA_W.
REQ-007 Ports per requester n: respN_valid out 1 (read data valid); respN_rdata out DATA_W.
REQ-008 Ports to the single-port SRAM: sram_en out 1; sram_wmode out 1; sram_addr out ADDR_W; sram_wdata out DATA_W; sram_rdata in DATA_W (valid one cycle after a read enable).
REQ-009 Port: init_done  out  1  high once the post-reset clear sweep completes.

Function
REQ-010 FSM states SHALL be INIT and RUN; reset enters INIT.
REQ-011 In INIT, per cycle: sram_en=1, sram_wmode=1, sram_wdata=0, sram_addr=init counter; both reqN_ready=0.
REQ-012 The init counter SHALL start at 0 and increment by 1 per cycle; after writing address DEPTH-1, the FSM SHALL enter RUN next cycle and init_done SHALL go to 1. Init SHALL last exactly DEPTH cycles.
REQ-013 In RUN, at most one request SHALL be granted per cycle; a transfer occurs when reqN_valid and reqN_ready are both 1.
REQ-014 reqN_ready SHALL be combinational: 1 in RUN when requester N wins arbitration or the other requester is not valid; 0 for the loser.
REQ-015 On grant, sram_en=1, sram_wmode=reqN_write, sram_addr=reqN_addr, sram_wdata=reqN_wdata in the same cycle. With no grant, sram_en=0 and the other SRAM outputs are don't-care.
REQ-016 A granted read SHALL assert respN_valid for exactly one cycle, the cycle after grant, with respN_rdata=sram_rdata (fixed 1-cycle latency); writes produce no response.
REQ-017 The block SHALL register the owner of each in-flight read, so back-to-back reads from alternating requesters return to the correct requester every cycle.
REQ-018 respN_rdata SHALL be don't-care when respN_valid=0; resp is not back-pressured and the requester must accept it.
REQ-019 Contention with the arbitration of REQ-026 SHALL also cover a read and a write to the same address in the same cycle: only one is granted, and the loser is served later in grant order.

Reset
REQ-020 On reset: FSM=INIT, init counter=0, init_done=0, resp0_valid=resp1_valid=0, read-owner register cleared, round-robin pointer=0 (requester 0 favoured).
REQ-021 Reset asserted mid-sweep or mid-RUN SHALL abort any in-flight response (no respN_valid after release) and restart the full sweep from address 0.
REQ-022 reqN_ready SHALL be 0 and sram_en SHALL be driven by INIT rules from the first cycle after reset release.

Configuration
REQ-023 Macro SRAM_ARB_RR_EN SHALL select the arbitration policy.
REQ-024 With SRAM_ARB_RR_EN defined, arbitration SHALL be round-robin: on simultaneous valid, the pointer-favoured requester wins, and after any grant the pointer SHALL point to the non-granted requester.
REQ-025 With a single valid requester, that requester SHALL be granted and the pointer SHALL still move to the other requester.
REQ-026 Without SRAM_ARB_RR_EN, arbitration SHALL be fixed priority: requester 0 always wins on contention, and the pointer register SHALL be absent.

Verification
REQ-027 Release reset, hold both valid: sram_en=1/wmode=1 at addresses 0..511 for 512 cycles, readies=0; init_done=1 and first grant in cycle 513.
REQ-028 After init, req0 write addr 5 data 0xBEEF, then req1 read addr 5: resp1_valid one cycle after grant with 0xBEEF; resp0_valid stays 0.
REQ-029 RR build, both requesters issue continuous reads: grants alternate 0,1,0,1; each resp goes to the issuing requester with latency 1.
REQ-030 Non-RR build, both requesters continuously valid: req0 granted every cycle, req1_ready stays 0; drop req0 and req1 is granted the same cycle.
REQ-031 Read addr 300 (never written) after init: resp_rdata=0x0000.
REQ-032 Assert reset the cycle after a read grant: no respN_valid after release; sweep restarts at address 0 with init_done=0.

Source files
------------

// File: rtl/sram_rw_arbiter.sv
// sram_rw_arbiter: two-requester front end for a single-port SRAM.
// After reset it clears every SRAM entry (INIT sweep) and then arbitrates
// read/write requests (RUN). Reads return one cycle after their grant to the
// requester that issued them.
// Build option: define SRAM_ARB_RR_EN for round-robin arbitration; without it
// requester 0 has fixed priority and there is no pointer register.
module sram_rw_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 512
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              resp0_valid,
    output logic [DATA_W-1:0] resp0_rdata,
    output logic              resp1_valid,
    output logic [DATA_W-1:0] resp1_rdata,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              init_done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_init_cnt;
    logic              r_init_done;
    logic              r_rd_pend;   // a read was granted last cycle
    logic              r_rd_owner;  // requester that owns that read (0/1)

    logic w_run;
    logic w_fav0;                   // requester 0 wins on contention
    logic w_rdy0;
    logic w_rdy1;
    logic w_gnt0;
    logic w_gnt1;

    assign w_run = (r_state == ST_RUN);

`ifdef SRAM_ARB_RR_EN
    logic r_ptr;                    // 0: requester 0 favoured, 1: requester 1

    // Round-robin pointer: after any grant, favour the requester not granted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ptr <= 1'b0;
        end else if (w_gnt0 | w_gnt1) begin
            r_ptr <= w_gnt0;
        end
    end

    assign w_fav0 = ~r_ptr;
`else
    assign w_fav0 = 1'b1;
`endif

    // A requester is ready when the other one is idle or when it wins contention.
    assign w_rdy0 = w_run & (~req1_valid | (req0_valid &  w_fav0));
    assign w_rdy1 = w_run & (~req0_valid | (req1_valid & ~w_fav0));
    assign w_gnt0 = req0_valid & w_rdy0;
    assign w_gnt1 = req1_valid & w_rdy1;

    assign req0_ready = w_rdy0;
    assign req1_ready = w_rdy1;
    assign init_done  = r_init_done;

    // Control FSM: clear sweep over every address, then run forever.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_INIT;
            r_init_cnt  <= '0;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    if (r_init_cnt == LAST_ADDR) begin
                        r_state     <= ST_RUN;
                        r_init_done <= 1'b1;
                        r_init_cnt  <= '0;
                    end else begin
                        r_init_cnt <= r_init_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    // Track the owner of the read in flight so its data is routed back correctly.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rd_pend  <= 1'b0;
            r_rd_owner <= 1'b0;
        end else begin
            r_rd_pend  <= (w_gnt0 & ~req0_write) | (w_gnt1 & ~req1_write);
            r_rd_owner <= w_gnt1;
        end
    end

    assign resp0_valid = r_rd_pend & ~r_rd_owner;
    assign resp1_valid = r_rd_pend &  r_rd_owner;
    assign resp0_rdata = sram_rdata;
    assign resp1_rdata = sram_rdata;

    // SRAM command mux: sweep writes during INIT, granted request during RUN.
    always_comb begin
        sram_en    = 1'b0;
        sram_wmode = req0_write;
        sram_addr  = req0_addr;
        sram_wdata = req0_wdata;
        if (!w_run) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = r_init_cnt;
            sram_wdata = '0;
        end else if (w_gnt1) begin
            sram_en    = 1'b1;
            sram_wmode = req1_write;
            sram_addr  = req1_addr;
            sram_wdata = req1_wdata;
        end else if (w_gnt0) begin
            sram_en    = 1'b1;
        end
    end

endmodule
